mux_sel_ctrl: RTL and testbench
===============================

Name: mux_sel_ctrl

Overview:
Front-panel select controller that drives the 3-bit `sel` input of the 5:1 output multiplexer.
- Synchronises and debounces three board push-buttons: up, down and centre.
- Turns each debounced press into a one-step change of the select index, wrapping within 0..NUM_INPUTS-1.
- Sits directly upstream of the mux; its `sel` output connects straight to the mux `sel` port.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a button level change (10 ms at 100 MHz); must be >= 2.
- NUM_INPUTS, 5, number of mux inputs; `sel` range is 0..NUM_INPUTS-1; legal range 2..2**SEL_W.
- SEL_W, 3, width of `sel`.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- btn_up  input  1  raw, asynchronous, bouncing button: increment select.
- btn_down  input  1  raw, asynchronous, bouncing button: decrement select.
- btn_center  input  1  raw, asynchronous, bouncing button: return select to 0.
- sel  output  SEL_W  registered select index to the mux.
- sel_changed  output  1  registered one-cycle pulse in the cycle after `sel` takes a new value.

Behaviour:
- Reset (rst sampled high at a rising edge):
  - `sel` = 0 and `sel_changed` = 0.
  - All synchroniser flops, debounced levels and debounce counters = 0.
  - Reset overrides every other event in the same cycle.
  - Reset asserted mid-debounce discards the partial count.
- Synchroniser: two flops per button (s1 then s2). Nothing downstream uses s1.
- Debouncer, per button, with a stable level `db` and a counter `cnt` of width clog2(DEBOUNCE_CYCLES):
  - If s2 == db: cnt <= 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: db <= s2, cnt <= 0.
  - Else: cnt <= cnt+1.
  - Result: `db` changes only after DEBOUNCE_CYCLES consecutive cycles of s2 disagreeing with it.
  - Any shorter glitch resets the count and has no effect.
- Press detect: press = db & ~db_q, where db_q is `db` delayed one cycle.
  - One pulse per accepted press.
  - No auto-repeat while the button is held.
  - Release is debounced the same way but produces no action.
- Select update, one registered step per cycle, priority order:
  1. Centre press: sel <= 0.
  2. Up and down pressed in the same cycle: no change.
  3. Up press: if sel == NUM_INPUTS-1 then sel <= 0, else sel <= sel+1.
  4. Down press: if sel == 0 then sel <= NUM_INPUTS-1, else sel <= sel-1.
  5. Otherwise: hold.
- sel_changed:
  - Asserted at the same edge `sel` is written, only if the new value differs from the old one.
  - Example: a centre press while sel == 0 gives no pulse.
  - Deasserted the following edge unless another change occurs.
- Latency: a button held high from edge 1 onward (first edge sampling it high):
  - s2 = 1 at edge 2.
  - db = 1 at edge 2+DEBOUNCE_CYCLES.
  - `sel` and `sel_changed` update at edge 3+DEBOUNCE_CYCLES.
- Range: `sel` never takes a value >= NUM_INPUTS, including after reset and at both wrap boundaries.
- Width: the increment compare is done at SEL_W bits; with NUM_INPUTS == 2**SEL_W the wrap is explicit, never overflow-dependent.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and NUM_INPUTS=5.
1. Reset, then clean btn_up held 20 cycles:
   - sel goes 0->1 at edge 7 after first high sample.
   - sel_changed high for exactly one cycle.
   - No further change while held or on release.
2. Five separate clean btn_up presses from sel=0:
   - sel goes 1,2,3,4,0 (wrap).
   - Five sel_changed pulses.
3. From sel=0, one btn_down press:
   - sel = 4 (wrap).
   - A second btn_down press gives sel = 3.
4. Bounce: btn_up toggling high 3 cycles / low 1 cycle for 16 cycles, then low:
   - sel unchanged.
   - sel_changed never asserted.
5. Simultaneous events, all with identical timing:
   - btn_up and btn_down pressed together: sel unchanged.
   - btn_center and btn_up pressed together from sel=3: sel = 0, one pulse.
   - btn_center at sel=0: no pulse.
6. rst asserted for 1 cycle while btn_up is 2 cycles into debounce at sel=2:
   - sel = 0 the next cycle.
   - The button, still held, then needs a full 2+4+1 edges to produce sel=1.

Source files
------------

// File: rtl/mux_sel_ctrl.sv
// -----------------------------------------------------------------------------
// mux_sel_ctrl
//
// Front-panel select controller for the 5:1 output multiplexer. Three raw
// push-buttons (up, down, centre) are synchronised, debounced and
// edge-detected. Each accepted press moves the select index by one step,
// wrapping within 0..NUM_INPUTS-1. Centre returns the index to 0.
//
// Handshake: none. The block has no valid/ready interface. `sel` is a plain
// registered level and `sel_changed` is a one-cycle registered strobe that
// accompanies every edge at which `sel` takes a new value.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous, active-high reset
//   btn_up       in   raw bouncing button, step select up (wraps to 0)
//   btn_down     in   raw bouncing button, step select down (wraps to max)
//   btn_center   in   raw bouncing button, return select to 0
//   sel          out  [SEL_W-1:0] registered select index to the mux
//   sel_changed  out  registered pulse, high for the cycle after `sel` changes
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable cycles to accept a level change (>= 2)
//   NUM_INPUTS       number of mux inputs, 2..2**SEL_W
//   SEL_W            width of `sel`
// -----------------------------------------------------------------------------
module mux_sel_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int NUM_INPUTS      = 5,
  parameter int SEL_W           = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_center,
  output logic [SEL_W-1:0] sel,
  output logic             sel_changed
);

  // Button index map used throughout the per-button vectors.
  localparam int BTN_UP     = 0;
  localparam int BTN_DOWN   = 1;
  localparam int BTN_CENTER = 2;
  localparam int NUM_BTN    = 3;

  localparam int                 CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [SEL_W-1:0]   SEL_MAX = SEL_W'(NUM_INPUTS - 1);
  localparam logic [SEL_W-1:0]   SEL_ZERO = '0;

  logic [NUM_BTN-1:0] w_raw;
  logic [NUM_BTN-1:0] w_db;
  logic [NUM_BTN-1:0] r_db_q;
  logic [NUM_BTN-1:0] w_press;

  assign w_raw = {btn_center, btn_down, btn_up};

  // ---------------------------------------------------------------------------
  // Per-button synchroniser and debouncer.
  // Each button owns its flops inside the generate scope so that no register
  // is shared between always blocks.
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    logic             r_s1;
    logic             r_s2;
    logic             r_db;
    logic [CNT_W-1:0] r_cnt;

    // Two-flop synchroniser. r_s1 may be metastable and feeds only r_s2.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_s1 <= 1'b0;
        r_s2 <= 1'b0;
      end else begin
        r_s1 <= w_raw[g];
        r_s2 <= r_s1;
      end
    end

    // Counter runs only while the synchronised level disagrees with the
    // accepted level; any agreeing cycle throws the partial count away, so
    // a glitch shorter than DEBOUNCE_CYCLES never reaches r_db.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_db  <= 1'b0;
        r_cnt <= '0;
      end else if (r_s2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_db  <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end

    assign w_db[g] = r_db;
  end

  // ---------------------------------------------------------------------------
  // Press detection: rising edge of the debounced level. Release edges are
  // ignored and a held button produces exactly one pulse.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_db_q <= '0;
    end else begin
      r_db_q <= w_db;
    end
  end

  assign w_press = w_db & ~r_db_q;

  // ---------------------------------------------------------------------------
  // Select update. Priority: centre, then up+down cancel, then up, then down.
  // The wrap compares are made at SEL_W bits and select the wrapped value
  // explicitly, so NUM_INPUTS == 2**SEL_W never relies on counter overflow.
  // ---------------------------------------------------------------------------
  logic [SEL_W-1:0] r_sel;
  logic             r_sel_changed;
  logic [SEL_W-1:0] w_sel_next;
  logic [SEL_W-1:0] w_sel_inc;
  logic [SEL_W-1:0] w_sel_dec;

  always_comb begin
    w_sel_inc = SEL_ZERO;
    w_sel_dec = SEL_MAX;
    if (r_sel != SEL_MAX) begin
      w_sel_inc = r_sel + SEL_W'(1);
    end
    if (r_sel != SEL_ZERO) begin
      w_sel_dec = r_sel - SEL_W'(1);
    end
  end

  always_comb begin
    w_sel_next = r_sel;
    if (w_press[BTN_CENTER]) begin
      w_sel_next = SEL_ZERO;
    end else if (w_press[BTN_UP] && w_press[BTN_DOWN]) begin
      w_sel_next = r_sel;
    end else if (w_press[BTN_UP]) begin
      w_sel_next = w_sel_inc;
    end else if (w_press[BTN_DOWN]) begin
      w_sel_next = w_sel_dec;
    end
  end

  // The change strobe compares against the value being replaced, so a
  // centre press while already at 0 writes 0 again without a pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel         <= SEL_ZERO;
      r_sel_changed <= 1'b0;
    end else begin
      r_sel         <= w_sel_next;
      r_sel_changed <= (w_sel_next != r_sel);
    end
  end

  assign sel         = r_sel;
  assign sel_changed = r_sel_changed;

endmodule

// File: tb/tb_mux_sel_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mux_sel_ctrl
//
// Bench for mux_sel_ctrl with DEBOUNCE_CYCLES=4, NUM_INPUTS=5, SEL_W=3.
// A table of press records (buttons, expected sel, expected pulse count) is
// applied in a loop; latency, bounce and mid-debounce reset are written out
// as explicit edge-by-edge sequences.
// -----------------------------------------------------------------------------
module tb_mux_sel_ctrl;

  localparam int DEB   = 4;
  localparam int NIN   = 5;
  localparam int SEL_W = 3;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             btn_up = 1'b0;
  logic             btn_down = 1'b0;
  logic             btn_center = 1'b0;
  logic [SEL_W-1:0] sel;
  logic             sel_changed;

  always #5 clk = ~clk;

  mux_sel_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .NUM_INPUTS     (NIN),
    .SEL_W          (SEL_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .btn_center (btn_center),
    .sel        (sel),
    .sel_changed(sel_changed)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [SEL_W-1:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // One active edge, then settle 1 time unit so outputs are sampled away
  // from the edge and new inputs are set up for the next one.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int mon_pulses;
  int mon_double;
  int mon_range;
  logic mon_prev;

  // tick plus observation of sel_changed and the sel range
  task automatic tick_mon();
    tick();
    if (sel_changed) mon_pulses++;
    if (sel_changed && mon_prev) mon_double++;
    if (sel >= SEL_W'(NIN)) mon_range++;
    mon_prev = sel_changed;
  endtask

  task automatic mon_clear();
    mon_pulses = 0;
    mon_double = 0;
    mon_range  = 0;
    mon_prev   = 1'b0;
  endtask

  task automatic set_btns(input logic u, input logic d, input logic c);
    btn_up     = u;
    btn_down   = d;
    btn_center = c;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    tick();
    tick();
    check({tag, "_reset_sel"}, int'(sel), 0);
    check({tag, "_reset_chg"}, int'(sel_changed), 0);
    rst = 1'b0;
  endtask

  // Clean press: buttons held 10 cycles then released 10 cycles, long
  // enough for both debounced edges to settle before the next press.
  task automatic press(input logic u, input logic d, input logic c);
    set_btns(u, d, c);
    for (int k = 0; k < 10; k++) tick_mon();
    set_btns(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) tick_mon();
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    string            name;
    logic             up;
    logic             down;
    logic             center;
    logic [SEL_W-1:0] exp_sel;
    int               exp_pulses;
  } vec_t;

  vec_t vecs[15];

  initial begin
    vecs[0]  = '{"up_0_1",      1'b1, 1'b0, 1'b0, 3'd1, 1};
    vecs[1]  = '{"up_1_2",      1'b1, 1'b0, 1'b0, 3'd2, 1};
    vecs[2]  = '{"up_2_3",      1'b1, 1'b0, 1'b0, 3'd3, 1};
    vecs[3]  = '{"up_3_4",      1'b1, 1'b0, 1'b0, 3'd4, 1};
    vecs[4]  = '{"up_wrap",     1'b1, 1'b0, 1'b0, 3'd0, 1};
    vecs[5]  = '{"down_wrap",   1'b0, 1'b1, 1'b0, 3'd4, 1};
    vecs[6]  = '{"down_4_3",    1'b0, 1'b1, 1'b0, 3'd3, 1};
    vecs[7]  = '{"up_down",     1'b1, 1'b1, 1'b0, 3'd3, 0};
    vecs[8]  = '{"ctr_up",      1'b1, 1'b0, 1'b1, 3'd0, 1};
    vecs[9]  = '{"ctr_at_0",    1'b0, 1'b0, 1'b1, 3'd0, 0};
    vecs[10] = '{"down_wrap2",  1'b0, 1'b1, 1'b0, 3'd4, 1};
    vecs[11] = '{"ctr_down",    1'b0, 1'b1, 1'b1, 3'd0, 1};
    vecs[12] = '{"all_three",   1'b1, 1'b1, 1'b1, 3'd0, 0};
    vecs[13] = '{"up_0_1b",     1'b1, 1'b0, 1'b0, 3'd1, 1};
    vecs[14] = '{"down_1_0",    1'b0, 1'b1, 1'b0, 3'd0, 1};
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    #2;
    do_reset("init");

    // --- Latency: btn_up held from edge 1, sel updates at edge 7 ----------
    mon_clear();
    btn_up = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick_mon();
      if (e == 6) begin
        check("lat_e6_sel", int'(sel), 0);
        check("lat_e6_chg", int'(sel_changed), 0);
      end
      if (e == 7) begin
        check("lat_e7_sel", int'(sel), 1);
        check("lat_e7_chg", int'(sel_changed), 1);
      end
      if (e == 8) check("lat_e8_chg", int'(sel_changed), 0);
    end
    btn_up = 1'b0;
    for (int k = 0; k < 10; k++) tick_mon();
    check("lat_final_sel", int'(sel), 1);
    check("lat_pulses", mon_pulses, 1);

    // --- Bounce: high 3 / low 1 for 16 cycles never reaches 4 stable -------
    mon_clear();
    for (int k = 0; k < 16; k++) begin
      btn_up = ((k % 4) != 3);
      tick_mon();
    end
    btn_up = 1'b0;
    for (int k = 0; k < 12; k++) tick_mon();
    check("bounce_sel", int'(sel), 1);
    check("bounce_pulses", mon_pulses, 0);

    // --- Table-driven presses -----------------------------------------------
    do_reset("tbl");
    for (int i = 0; i < 15; i++) begin
      exp_q.push_back(vecs[i].exp_sel);
    end
    for (int i = 0; i < 15; i++) begin
      logic [SEL_W-1:0] exp_sel;
      mon_clear();
      press(vecs[i].up, vecs[i].down, vecs[i].center);
      exp_sel = exp_q.pop_front();
      check({vecs[i].name, "_sel"}, int'(sel), int'(exp_sel));
      check({vecs[i].name, "_pulses"}, mon_pulses, vecs[i].exp_pulses);
      check({vecs[i].name, "_double"}, mon_double, 0);
      check({vecs[i].name, "_range"}, mon_range, 0);
    end

    // --- Reset mid-debounce at sel=2 ------------------------------------
    mon_clear();
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    check("mid_pre_sel", int'(sel), 2);
    btn_up = 1'b1;
    for (int e = 1; e <= 4; e++) tick();   // s2 high at edge 2, count 2 at edge 4
    check("mid_pre_rst_sel", int'(sel), 2);
    rst = 1'b1;
    tick();
    check("mid_rst_sel", int'(sel), 0);
    check("mid_rst_chg", int'(sel_changed), 0);
    rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 6) check("mid_e6_sel", int'(sel), 0);
      if (e == 7) begin
        check("mid_e7_sel", int'(sel), 1);
        check("mid_e7_chg", int'(sel_changed), 1);
      end
    end
    btn_up = 1'b0;
    for (int k = 0; k < 10; k++) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
